// File: rtl/key_event_queue_if.sv
// Handshake bundle between the keypad scanner/consumer side and key_event_queue.
interface key_event_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic [3:0]    key_data;
  logic          key_ready;
  logic [1:0]    evt_code;
  logic          evt_repeat;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          bad_code;
  logic          clear_flags;

  modport master (
    output key_data, key_ready, evt_ready, clear_flags,
    input  evt_code, evt_repeat, evt_valid, fifo_count, overflow, bad_code
  );

  modport slave (
    input  key_data, key_ready, evt_ready, clear_flags,
    output evt_code, evt_repeat, evt_valid, fifo_count, overflow, bad_code
  );
endinterface

// File: rtl/key_event_queue.sv
// Turns confirmed key presses into press/auto-repeat events and buffers them
// in a show-ahead FIFO drained through a valid/ready handshake.
module key_event_queue #(
  parameter  int DEPTH         = 4,
  parameter  int REPEAT_DELAY  = 16,
  parameter  int REPEAT_PERIOD = 8,
  localparam int CW            = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  key_event_queue_if.slave bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int MAXC = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNTW = $clog2(MAXC);
  localparam logic [CNTW-1:0] DLY_LAST = CNTW'(REPEAT_DELAY - 1);
  localparam logic [CNTW-1:0] PER_LAST = CNTW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} state_t;

  // Bit 2 flags a legal one-cold pattern, bits 1:0 carry the row index.
  function automatic logic [2:0] decode_row(input logic [3:0] d);
    logic [2:0] r;
    case (d)
      4'b0111: r = 3'b100;
      4'b1011: r = 3'b101;
      4'b1101: r = 3'b110;
      4'b1110: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [CNTW-1:0] cnt_r, cnt_s;
  logic [1:0]      code_r, code_s;
  logic            kr_q_r;
  logic            press_s, push_s, push_rep_s, bad_set_s;
  logic [2:0]      dec_s;

  logic [2:0]      mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_s;
  logic            valid_r, full_s, pop_s, wr_en_s, ovf_set_s;
  logic            ovf_r, bad_r;

  assign press_s = bus.key_ready & ~kr_q_r;
  assign dec_s   = decode_row(bus.key_data);

  // Key-hold FSM: next state, counter, latched code and push requests.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    code_s     = code_r;
    push_s     = 1'b0;
    push_rep_s = 1'b0;
    bad_set_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (press_s) begin
          if (dec_s[2]) begin
            code_s  = dec_s[1:0];
            push_s  = 1'b1;
            cnt_s   = '0;
            state_s = DELAY;
          end else begin
            bad_set_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DELAY: begin
        if (!bus.key_ready) begin
          state_s = IDLE;
        end else if (cnt_r == DLY_LAST) begin
          push_s     = 1'b1;
          push_rep_s = 1'b1;
          cnt_s      = '0;
          state_s    = REPEAT;
        end else begin
          cnt_s = cnt_r + CNTW'(1);
        end
      end
      REPEAT: begin
        if (!bus.key_ready) begin
          state_s = IDLE;
        end else if (cnt_r == PER_LAST) begin
          push_s     = 1'b1;
          push_rep_s = 1'b1;
          cnt_s      = '0;
        end else begin
          cnt_s = cnt_r + CNTW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // FSM state, hold counter, latched code and key_ready edge register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      code_r  <= 2'b00;
      kr_q_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      code_r  <= code_s;
      kr_q_r  <= bus.key_ready;
    end
  end

  assign full_s    = (count_r == CW'(DEPTH));
  assign pop_s     = valid_r & bus.evt_ready;
  assign wr_en_s   = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & full_s & ~pop_s;

  // Occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_s = count_r + CW'(1);
      2'b01:   count_s = count_r - CW'(1);
      default: count_s = count_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 3'b000;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      bad_r    <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {code_s, push_rep_s};
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_s;
      valid_r <= (count_s != '0);
      // A set in the same cycle as clear_flags keeps the flag high.
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (bus.clear_flags) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      if (bad_set_s) begin
        bad_r <= 1'b1;
      end else if (bus.clear_flags) begin
        bad_r <= 1'b0;
      end else begin
        bad_r <= bad_r;
      end
    end
  end

  assign bus.evt_valid  = valid_r;
  assign bus.evt_code   = valid_r ? mem_r[rd_ptr_r][2:1] : 2'b00;
  assign bus.evt_repeat = valid_r ? mem_r[rd_ptr_r][0]   : 1'b0;
  assign bus.fifo_count = count_r;
  assign bus.overflow   = ovf_r;
  assign bus.bad_code   = bad_r;
endmodule
